// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multicycle MIPS control FSM and ALU decoder
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        ADDIEX  = 4'd10,
        ADDIWB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational ALUOp + funct to 3-bit ALU operation code
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                // Unknown funct falls back to add; the writeback still happens.
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// rtl/mips_mc_control.sv - multicycle MIPS main control FSM driving datapath selects and enables
module mips_mc_control
    import mips_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_ctrl,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t     state_q;
    state_t     state_d;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] alu_op;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= state_t'(RESET_STATE);
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_op        = ALUOP_ADD;
        illegal_op    = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 2'b01;
                state_d   = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDIEX;
                    default: begin
                        state_d    = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ADDIWB;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = MEMWB;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            ADDIWB: begin
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            default: state_d = FETCH;
        endcase

        // Reset kills every side effect in the same cycle, not just the next state.
        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            pc_source     = 2'b00;
            alu_op        = ALUOP_ADD;
            illegal_op    = 1'b0;
        end
    end

    assign pc_en = pc_write | (pc_write_cond & zero);
    assign state = state_q;

    alu_decoder u_alu_decoder (
        .alu_op   (alu_op),
        .funct    (funct),
        .alu_ctrl (alu_ctrl)
    );

endmodule
